// File: rtl/ped_service_scheduler.sv
// Pedestrian service scheduler: latches NS/EW button presses, arbitrates round-robin,
// requests an all-red window, then times WALK, CLEAR and the vehicle GAP. Optional: EMERG_PREEMPT_EN.
module ped_service_scheduler #(
  parameter int unsigned WALK_CYCLES  = 8,
  parameter int unsigned CLEAR_CYCLES = 4,
  parameter int unsigned GAP_CYCLES   = 6,
  parameter int unsigned CNT_W        = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_ns,
  input  logic btn_ew,
  input  logic svc_grant,
`ifdef EMERG_PREEMPT_EN
  input  logic emerg,
`endif
  output logic svc_req,
  output logic svc_dir,
  output logic walk_ns,
  output logic walk_ew,
  output logic clear_ns,
  output logic clear_ew,
  output logic pend_ns,
  output logic pend_ew,
  output logic svc_done
);

  typedef enum logic [2:0] {IDLE, REQ, WALK, CLEAR, GAP} state_t;

  localparam logic [CNT_W-1:0] WALK_LD  = CNT_W'(WALK_CYCLES - 1);
  localparam logic [CNT_W-1:0] CLEAR_LD = CNT_W'(CLEAR_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LD   = CNT_W'(GAP_CYCLES - 1);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             dir_q, dir_nxt;
  logic             last_dir, last_dir_nxt;
  logic             btn_q_ns, btn_q_ew;
  logic             pend_ns_nxt, pend_ew_nxt;
  logic             rise_ns, rise_ew;
  logic             grant_take;
  logic             emerg_i;
  logic             busy;

`ifdef EMERG_PREEMPT_EN
  assign emerg_i = emerg;
`else
  assign emerg_i = 1'b0;
`endif

  assign rise_ns = btn_ns & ~btn_q_ns;
  assign rise_ew = btn_ew & ~btn_q_ew;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      cnt      <= '0;
      dir_q    <= 1'b0;
      last_dir <= 1'b1;
      btn_q_ns <= 1'b0;
      btn_q_ew <= 1'b0;
      pend_ns  <= 1'b0;
      pend_ew  <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      dir_q    <= dir_nxt;
      last_dir <= last_dir_nxt;
      btn_q_ns <= btn_ns;
      btn_q_ew <= btn_ew;
      pend_ns  <= pend_ns_nxt;
      pend_ew  <= pend_ew_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    dir_nxt      = dir_q;
    last_dir_nxt = last_dir;
    grant_take   = 1'b0;
    unique case (state)
      IDLE: begin
        if (pend_ns | pend_ew) begin
          // both pending: serve the direction not served last
          dir_nxt   = (pend_ns & pend_ew) ? ~last_dir : pend_ew;
          state_nxt = REQ;
        end
      end
      REQ: begin
        if (emerg_i) begin
          state_nxt = GAP;
          cnt_nxt   = GAP_LD;
        end else if (svc_grant) begin
          grant_take   = 1'b1;
          last_dir_nxt = dir_q;
          cnt_nxt      = WALK_LD;
          state_nxt    = WALK;
        end
      end
      WALK: begin
        if (!svc_grant || emerg_i || cnt == '0) begin
          state_nxt = CLEAR;
          cnt_nxt   = CLEAR_LD;
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      CLEAR: begin
        if (cnt == '0) begin
          state_nxt = GAP;
          cnt_nxt   = GAP_LD;
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      GAP: begin
        if (cnt != '0) begin
          cnt_nxt = cnt - 1'b1;
        end else if (!emerg_i) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // presses for the direction currently walking are dropped; grant acceptance clears
  always_comb begin
    pend_ns_nxt = pend_ns;
    pend_ew_nxt = pend_ew;
    if (rise_ns && !(state == WALK && dir_q == 1'b0)) pend_ns_nxt = 1'b1;
    if (rise_ew && !(state == WALK && dir_q == 1'b1)) pend_ew_nxt = 1'b1;
    if (grant_take && dir_q == 1'b0) pend_ns_nxt = 1'b0;
    if (grant_take && dir_q == 1'b1) pend_ew_nxt = 1'b0;
  end

  assign busy     = (state == REQ) || (state == WALK) || (state == CLEAR);
  assign svc_req  = busy;
  assign svc_dir  = busy & dir_q;
  assign walk_ns  = (state == WALK)  & ~dir_q;
  assign walk_ew  = (state == WALK)  &  dir_q;
  assign clear_ns = (state == CLEAR) & ~dir_q;
  assign clear_ew = (state == CLEAR) &  dir_q;
  assign svc_done = (state == CLEAR) && (cnt == '0);

endmodule

// File: tb/tb_ped_service_scheduler.sv
// Directed bench for ped_service_scheduler: vector table plus hand-written service sequences.
// Output vector order: {svc_req, svc_dir, walk_ns, walk_ew, clear_ns, clear_ew, pend_ns, pend_ew, svc_done}.
module tb_ped_service_scheduler;

  logic clk, rst, btn_ns, btn_ew, svc_grant;
  logic svc_req, svc_dir, walk_ns, walk_ew, clear_ns, clear_ew, pend_ns, pend_ew, svc_done;
`ifdef EMERG_PREEMPT_EN
  logic emerg;
`endif
  logic [8:0] act;
  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       bn;
    logic       be;
    logic       g;
    logic [8:0] exp;
  } vec_t;
  vec_t tbl[22];

  ped_service_scheduler #(.WALK_CYCLES(8), .CLEAR_CYCLES(4), .GAP_CYCLES(6), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .btn_ns(btn_ns), .btn_ew(btn_ew), .svc_grant(svc_grant),
`ifdef EMERG_PREEMPT_EN
    .emerg(emerg),
`endif
    .svc_req(svc_req), .svc_dir(svc_dir), .walk_ns(walk_ns), .walk_ew(walk_ew),
    .clear_ns(clear_ns), .clear_ew(clear_ew), .pend_ns(pend_ns), .pend_ew(pend_ew),
    .svc_done(svc_done)
  );

  assign act = {svc_req, svc_dir, walk_ns, walk_ew, clear_ns, clear_ew, pend_ns, pend_ew, svc_done};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc(input logic bn, input logic be, input logic g, input logic [8:0] exp,
                     input string name);
    @(negedge clk);
    btn_ns = bn; btn_ew = be; svc_grant = g;
    @(posedge clk);
    #1;
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b want %b", name, act, exp);
    end
    checks++;
    if ((walk_ns & clear_ns) | (walk_ew & clear_ew) | ((walk_ns | clear_ns) & (walk_ew | clear_ew))) begin
      errors++;
      $display("FAIL %s_excl: got wn%b we%b cn%b ce%b want no overlap", name, walk_ns, walk_ew, clear_ns, clear_ew);
    end
  endtask

  task automatic rep(input int n, input logic bn, input logic be, input logic g,
                     input logic [8:0] exp, input string name);
    for (int i = 0; i < n; i++) cyc(bn, be, g, exp, name);
  endtask

  // Reset is asserted between edges so an asynchronous clear is observed immediately.
  task automatic do_reset(input string name);
    @(negedge clk);
    rst = 1'b0; btn_ns = 1'b0; btn_ew = 1'b0; svc_grant = 1'b0;
`ifdef EMERG_PREEMPT_EN
    emerg = 1'b0;
`endif
    #1;
    checks++;
    if (act !== 9'b0) begin
      errors++;
      $display("FAIL %s: got %b want %b", name, act, 9'b0);
    end
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    rst = 1'b0; btn_ns = 1'b0; btn_ew = 1'b0; svc_grant = 1'b0;
`ifdef EMERG_PREEMPT_EN
    emerg = 1'b0;
`endif

    // NS single service with grant held, then a press during GAP is served after GAP.
    tbl[0]  = '{1'b1, 1'b0, 1'b0, 9'b000000100};
    tbl[1]  = '{1'b1, 1'b0, 1'b0, 9'b100000100};
    for (int i = 2; i <= 9; i++)   tbl[i] = '{1'b0, 1'b0, 1'b1, 9'b101000000};
    for (int i = 10; i <= 12; i++) tbl[i] = '{1'b0, 1'b0, 1'b1, 9'b100010000};
    tbl[13] = '{1'b0, 1'b0, 1'b1, 9'b100010001};
    tbl[14] = '{1'b0, 1'b0, 1'b0, 9'b000000000};
    for (int i = 15; i <= 20; i++) tbl[i] = '{1'b1, 1'b0, 1'b0, 9'b000000100};
    tbl[21] = '{1'b1, 1'b0, 1'b0, 9'b100000100};

    do_reset("reset_initial");
    for (int i = 0; i < 22; i++)
      cyc(tbl[i].bn, tbl[i].be, tbl[i].g, tbl[i].exp, $sformatf("tbl%0d", i));

    // Async reset while in REQ; then simultaneous presses: NS first, then EW.
    do_reset("reset_mid_req");
    cyc(1, 1, 0, 9'b000000110, "both_pend");
    cyc(1, 1, 0, 9'b100000110, "both_req_ns");
    rep(8, 0, 0, 1, 9'b101000010, "both_ns_walk");
    rep(3, 0, 0, 1, 9'b100010010, "both_ns_clear");
    cyc(0, 0, 1, 9'b100010011, "both_ns_done");
    rep(6, 0, 0, 0, 9'b000000010, "both_gap");
    cyc(0, 0, 0, 9'b000000010, "both_idle");
    cyc(0, 0, 0, 9'b110000010, "both_req_ew");
    rep(8, 0, 0, 1, 9'b110100000, "both_ew_walk");
    rep(3, 0, 0, 1, 9'b110001000, "both_ew_clear");
    cyc(0, 0, 1, 9'b110001001, "both_ew_done");
    cyc(0, 0, 0, 9'b000000000, "both_ew_gap");

    // Re-press during WALK ignored, during CLEAR latched and served again.
    do_reset("reset_mid_gap");
    cyc(1, 0, 0, 9'b000000100, "rp_pend");
    cyc(1, 0, 0, 9'b100000100, "rp_req");
    cyc(0, 0, 1, 9'b101000000, "rp_walk1");
    cyc(1, 0, 1, 9'b101000000, "rp_walk_press_ignored");
    rep(6, 0, 0, 1, 9'b101000000, "rp_walk");
    cyc(0, 0, 1, 9'b100010000, "rp_clear1");
    cyc(1, 0, 1, 9'b100010100, "rp_clear_press_latched");
    cyc(1, 0, 1, 9'b100010100, "rp_clear3");
    cyc(1, 0, 1, 9'b100010101, "rp_done");
    rep(6, 1, 0, 0, 9'b000000100, "rp_gap");
    cyc(1, 0, 0, 9'b000000100, "rp_idle");
    cyc(1, 0, 0, 9'b100000100, "rp_req2");
    cyc(0, 0, 1, 9'b101000000, "rp_walk_again");

    // Grant drops in the 3rd WALK cycle: full CLEAR, done pulse, grant loss in CLEAR ignored.
    do_reset("reset_mid_walk");
    cyc(1, 0, 0, 9'b000000100, "gl_pend");
    cyc(0, 0, 0, 9'b100000100, "gl_req");
    rep(3, 0, 0, 1, 9'b101000000, "gl_walk");
    rep(3, 0, 0, 0, 9'b100010000, "gl_clear");
    cyc(0, 0, 0, 9'b100010001, "gl_done");
    cyc(0, 0, 0, 9'b000000000, "gl_gap");

`ifdef EMERG_PREEMPT_EN
    // Emergency in REQ: request withdrawn, pend kept, no done; resumes after emerg falls and GAP.
    do_reset("reset_emerg");
    cyc(1, 0, 0, 9'b000000100, "em_pend");
    cyc(1, 0, 0, 9'b100000100, "em_req");
    emerg = 1'b1;
    rep(9, 1, 0, 0, 9'b000000100, "em_hold");
    emerg = 1'b0;
    cyc(1, 0, 0, 9'b000000100, "em_idle");
    cyc(1, 0, 0, 9'b100000100, "em_req_resume");
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ped_service_scheduler.md
Name: ped_service_scheduler

Overview:
- Schedules pedestrian crossing service for the traffic_controller intersection.
- Latches NS/EW pedestrian button presses and arbitrates between them round-robin.
- Requests an all-red window from the traffic controller through a req/grant handshake, then times the WALK and CLEAR intervals and enforces a minimum vehicle gap before the next service.

Parameters:
WALK_CYCLES, 8, clock cycles walk_* is held high per service (>=1)
CLEAR_CYCLES, 4, clock cycles clear_* (flashing don't-walk) is held high (>=1)
GAP_CYCLES, 6, minimum idle cycles after a service before a new svc_req (>=1)
CNT_W, 8, interval counter width; every *_CYCLES value must be <= 2^CNT_W

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-low reset (0 = reset)
btn_ns  input  1  NS pedestrian button level, synchronous to clk
btn_ew  input  1  EW pedestrian button level, synchronous to clk
svc_grant  input  1  from traffic controller: intersection is all-red and held for pedestrians
svc_req  output  1  request for the all-red pedestrian window
svc_dir  output  1  direction being served (0 = NS, 1 = EW); valid while svc_req = 1
walk_ns / walk_ew  output  1  walk indication for each direction
clear_ns / clear_ew  output  1  clearance (flashing don't-walk) indication for each direction
pend_ns / pend_ew  output  1  latched pending request status
svc_done  output  1  one-cycle pulse when a service completes or is aborted

Behaviour:
- Reset (rst = 0, asynchronous):
  - All outputs 0; state IDLE; counter 0; btn_q registers 0; pend 0.
  - last_dir = 1 (EW), so NS wins the first tie.
- Request latching:
  - pend_x is set on a rising edge, detected as btn_x & ~btn_q_x, and is visible the cycle after btn_x is first sampled high.
  - pend_x clears only on the cycle svc_grant is accepted for direction x.
  - A rising edge for x while x is in WALK is ignored.
  - Rising edges in any other state, including CLEAR and GAP of the same direction, are latched.
- States: IDLE, REQ, WALK, CLEAR, GAP.
- IDLE:
  - If any pend is set, select a direction: the single pending one, or ~last_dir when both are pending.
  - Register svc_dir and go to REQ, asserting svc_req the next cycle. svc_req therefore rises 2 cycles after the button is first sampled high.
- REQ:
  - Hold svc_req = 1 and svc_dir stable until svc_grant = 1 is sampled. The wait is unbounded.
  - On grant: clear pend[svc_dir], set last_dir = svc_dir, load counter = WALK_CYCLES-1, go to WALK.
- WALK:
  - walk_[svc_dir] = 1 for exactly WALK_CYCLES cycles; the counter decrements each cycle.
  - At count 0: load CLEAR_CYCLES-1 and go to CLEAR.
- CLEAR:
  - clear_[svc_dir] = 1 for exactly CLEAR_CYCLES cycles.
  - At count 0: pulse svc_done, load GAP_CYCLES-1, go to GAP.
- svc_req stays 1 through REQ, WALK and CLEAR, and is 0 from the first GAP cycle.
- GAP: all walk/clear outputs 0 for GAP_CYCLES cycles, then return to IDLE.
- Grant loss: if svc_grant drops during WALK, walk is removed on the next cycle and the block enters CLEAR with the full CLEAR_CYCLES. Grant loss during CLEAR is ignored.
- Invariants:
  - walk_x and clear_x are never both 1.
  - The walk/clear outputs of at most one direction are active at a time.
- Reset asserted mid-service: all outputs drop immediately, because reset is asynchronous.

Optional Feature:
- Macro: EMERG_PREEMPT_EN.
- When defined, the block adds input emerg (1 bit).
  - In REQ with emerg = 1: drop svc_req, keep pend, go to GAP.
  - In WALK with emerg = 1: go straight to CLEAR (full CLEAR_CYCLES), then to GAP.
  - While emerg = 1, GAP does not exit to IDLE.
  - svc_done pulses only for preemptions that leave WALK or CLEAR.
- When not defined: no emerg port; behaviour exactly as above.

Test Plan:
- Reset release, btn_ns high from cycle 2 -> pend_ns at cycle 3; svc_req = 1 with svc_dir = 0 at cycle 4; all outputs 0 before that.
- Grant held high -> walk_ns high 8 cycles, clear_ns high 4 cycles, svc_done 1 pulse, svc_req low; next svc_req no earlier than 6 cycles later.
- btn_ns and btn_ew rise on the same cycle after reset -> NS served first, then EW; both pend flags cleared in order; no overlap of walk/clear across directions.
- btn_ns re-pressed during NS WALK -> ignored (pend_ns stays 0). Re-pressed during CLEAR -> pend_ns = 1, and NS is served again after GAP.
- svc_grant dropped in the 3rd WALK cycle -> walk_ns low the next cycle, clear_ns 4 cycles, svc_done pulse.
- With EMERG_PREEMPT_EN: emerg during REQ -> svc_req drops, pend retained, no svc_done; service resumes only after emerg falls and GAP elapses.
